ahb_bram_arbiter: RTL and testbench

AHB_BRAM_ARBITER -- requirements
Module: ahb_bram_arbiter

---
 rtl/ahb_bram_arbiter_pkg.sv | 31 +++
 rtl/ahb_bram_arbiter_if.sv | 39 +++
 rtl/ahb_input_stage.sv | 63 ++++++
 rtl/ahb_bram_arbiter.sv | 129 ++++++++++++
 tb/tb_ahb_bram_arbiter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_bram_arbiter_pkg.sv
// Shared constants and types for the two-master AHB-lite BRAM arbiter.
package ahb_bram_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Owner of the slave data phase currently in progress.
  typedef enum logic [1:0] {
    DP_IDLE = 2'b00,
    OWN_M0  = 2'b01,
    OWN_M1  = 2'b10
  } dp_owner_e;

  // Grant encoding, also used for the last-granted master.
  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } grant_e;

  // Address/control captured for a transfer that lost arbitration.
  typedef struct packed {
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
  } hold_t;

  function automatic dp_owner_e owner_of(grant_e g);
    return (g == M0) ? OWN_M0 : OWN_M1;
  endfunction

endpackage

// File: rtl/ahb_bram_arbiter_if.sv
// AHB-lite link: one instance per master port and one toward the BRAM.
interface ahb_bram_arbiter_if;

  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  // AHB master driving a link.
  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HREADY, HRDATA, HRESP
  );

  // Slave end of a master link (arbiter input side).
  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    output HREADY, HRDATA, HRESP
  );

  // Arbiter toward the BRAM: it also drives HREADY and sees HREADYOUT.
  modport bridge (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA
  );

  // The BRAM itself.
  modport bram (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );

endinterface

// File: rtl/ahb_input_stage.sv
// Per-master front end: pending-transfer capture and HREADY generation.
module ahb_input_stage
  import ahb_bram_arbiter_pkg::*;
(
  input  logic               HCLK,
  input  logic               HRESETn,
  ahb_bram_arbiter_if.slave  bus,
  input  logic               is_owner,
  input  logic               fwd_live,
  input  logic               fwd_hold,
  input  logic               s_hreadyout,
  input  logic [31:0]        s_hrdata,
  output logic               live,
  output logic               pend,
  output hold_t              hold
);

  logic  pend_q, pend_d;
  hold_t hold_q, hold_d;
  logic  hready;
  logic  unused_htrans0;

  assign unused_htrans0 = bus.HTRANS[0];

  // HREADY never looks at the grant, which keeps the grant loop-free.
  always_comb begin
    hready = is_owner ? s_hreadyout : ~pend_q;
    live   = bus.HSEL & bus.HTRANS[1] & hready;
  end

  // A live transfer not forwarded this edge is parked; a parked one clears when forwarded.
  always_comb begin
    pend_d = pend_q;
    hold_d = hold_q;
    if (live && !fwd_live) begin
      pend_d = 1'b1;
      hold_d = '{haddr: bus.HADDR, hwrite: bus.HWRITE, hsize: bus.HSIZE};
    end else if (fwd_hold) begin
      pend_d = 1'b0;
    end
  end

  // Pending state and held address/control.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_q <= 1'b0;
      hold_q <= '0;
    end else begin
      pend_q <= pend_d;
      hold_q <= hold_d;
    end
  end

  // Response back to the master.
  always_comb begin
    bus.HREADY = hready;
    bus.HRDATA = s_hrdata;
    bus.HRESP  = 1'b0;
    pend       = pend_q;
    hold       = hold_q;
  end

endmodule

// File: rtl/ahb_bram_arbiter.sv
// Two-master AHB-lite arbiter in front of a single BRAM slave.
module ahb_bram_arbiter
  import ahb_bram_arbiter_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  ahb_bram_arbiter_if.slave  m0,
  ahb_bram_arbiter_if.slave  m1,
  ahb_bram_arbiter_if.bridge s
);

  logic      live0, live1, pend0, pend1;
  hold_t     hold0, hold1;
  dp_owner_e dp_q, dp_d;
  grant_e    last_q, last_d, gnt;
  logic      gnt_vld;
  hold_t     fwd_ctl, s_ctl_q, s_ctl_d;
  logic      fwd_live0, fwd_hold0, fwd_live1, fwd_hold1;

  ahb_input_stage u_stage0 (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .bus         (m0),
    .is_owner    (dp_q == OWN_M0),
    .fwd_live    (fwd_live0),
    .fwd_hold    (fwd_hold0),
    .s_hreadyout (s.HREADYOUT),
    .s_hrdata    (s.HRDATA),
    .live        (live0),
    .pend        (pend0),
    .hold        (hold0)
  );

  ahb_input_stage u_stage1 (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .bus         (m1),
    .is_owner    (dp_q == OWN_M1),
    .fwd_live    (fwd_live1),
    .fwd_hold    (fwd_hold1),
    .s_hreadyout (s.HREADYOUT),
    .s_hrdata    (s.HRDATA),
    .live        (live1),
    .pend        (pend1),
    .hold        (hold1)
  );

  // Grant: sole requester wins; ties go to the master not granted last (or M0 if fixed).
  always_comb begin
    logic req0, req1;
    req0    = pend0 | live0;
    req1    = pend1 | live1;
    gnt     = M0;
    gnt_vld = 1'b0;
    // Gated by reset so nothing reaches the slave while HRESETn is low.
    if (HRESETn && s.HREADYOUT) begin
      if (req0 && req1) begin
        gnt_vld = 1'b1;
        gnt     = (FIXED_PRIO != 0) ? M0 : ((last_q == M0) ? M1 : M0);
      end else if (req0) begin
        gnt_vld = 1'b1;
        gnt     = M0;
      end else if (req1) begin
        gnt_vld = 1'b1;
        gnt     = M1;
      end
    end
  end

  // Address/control mux: held copy if the winner is pending, else its live bus.
  always_comb begin
    if (gnt == M0) begin
      fwd_ctl = pend0 ? hold0 : '{haddr: m0.HADDR, hwrite: m0.HWRITE, hsize: m0.HSIZE};
    end else begin
      fwd_ctl = pend1 ? hold1 : '{haddr: m1.HADDR, hwrite: m1.HWRITE, hsize: m1.HSIZE};
    end
    fwd_live0 = gnt_vld & (gnt == M0) & ~pend0;
    fwd_hold0 = gnt_vld & (gnt == M0) & pend0;
    fwd_live1 = gnt_vld & (gnt == M1) & ~pend1;
    fwd_hold1 = gnt_vld & (gnt == M1) & pend1;
  end

  // Next data-phase owner, last grant and last forwarded address/control.
  always_comb begin
    dp_d    = dp_q;
    last_d  = last_q;
    s_ctl_d = s_ctl_q;
    if (s.HREADYOUT) begin
      dp_d = gnt_vld ? owner_of(gnt) : DP_IDLE;
    end
    if (gnt_vld) begin
      last_d  = gnt;
      s_ctl_d = fwd_ctl;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_q    <= DP_IDLE;
      last_q  <= M1;
      s_ctl_q <= '0;
    end else begin
      dp_q    <= dp_d;
      last_q  <= last_d;
      s_ctl_q <= s_ctl_d;
    end
  end

  // Slave-side outputs; every forwarded beat goes out as NONSEQ.
  always_comb begin
    hold_t ctl;
    ctl      = gnt_vld ? fwd_ctl : s_ctl_q;
    s.HSEL   = gnt_vld;
    s.HTRANS = gnt_vld ? HTRANS_NONSEQ : HTRANS_IDLE;
    s.HADDR  = ctl.haddr;
    s.HWRITE = ctl.hwrite;
    s.HSIZE  = ctl.hsize;
    s.HREADY = s.HREADYOUT;
    unique case (dp_q)
      OWN_M0:  s.HWDATA = m0.HWDATA;
      OWN_M1:  s.HWDATA = m1.HWDATA;
      default: s.HWDATA = '0;
    endcase
  end

endmodule

// File: tb/tb_ahb_bram_arbiter.sv
// Directed self-checking bench for ahb_bram_arbiter with a small BRAM model.
module tb_ahb_bram_arbiter;
  import ahb_bram_arbiter_pkg::*;

  localparam logic [1:0] HTRANS_SEQ = 2'b11;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb_bram_arbiter_if m0_if ();
  ahb_bram_arbiter_if m1_if ();
  ahb_bram_arbiter_if s_if ();
  ahb_bram_arbiter_if f0_if ();
  ahb_bram_arbiter_if f1_if ();
  ahb_bram_arbiter_if fs_if ();

  ahb_bram_arbiter #(.FIXED_PRIO(0)) u_dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .m0      (m0_if),
    .m1      (m1_if),
    .s       (s_if)
  );

  ahb_bram_arbiter #(.FIXED_PRIO(1)) u_fix (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .m0      (f0_if),
    .m1      (f1_if),
    .s       (fs_if)
  );

  int n_pass = 0;
  int n_chk  = 0;

  // BRAM model: registered address phase, combinational read, byte-lane writes.
  logic        slv_ready = 1'b1;
  logic [31:0] mem [0:255];
  logic        dv_q, dw_q;
  logic [7:0]  da_q;
  logic [1:0]  dl_q;
  logic [2:0]  ds_q;
  int unsigned wr_cnt = 0;

  assign s_if.HREADYOUT  = slv_ready;
  assign s_if.HRDATA     = mem[da_q];
  assign s_if.HRESP      = 1'b0;
  assign fs_if.HREADYOUT = 1'b1;
  assign fs_if.HRDATA    = 32'h0;
  assign fs_if.HRESP     = 1'b0;
  assign m0_if.HREADYOUT = 1'b1;
  assign m1_if.HREADYOUT = 1'b1;
  assign f0_if.HREADYOUT = 1'b1;
  assign f1_if.HREADYOUT = 1'b1;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [2:0] sz,
                                        logic [1:0] ln);
    logic [3:0]  be;
    logic [31:0] r;
    case (sz)
      3'd0:    be = 4'b0001 << ln;
      3'd1:    be = ln[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dv_q <= 1'b0;
      dw_q <= 1'b0;
      da_q <= '0;
      dl_q <= '0;
      ds_q <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + 32'(i);
    end else if (s_if.HREADY) begin
      if (dv_q && dw_q) begin
        mem[da_q] <= merge(mem[da_q], s_if.HWDATA, ds_q, dl_q);
        wr_cnt    <= wr_cnt + 1;
      end
      dv_q <= s_if.HSEL & s_if.HTRANS[1];
      dw_q <= s_if.HWRITE;
      da_q <= s_if.HADDR[9:2];
      dl_q <= s_if.HADDR[1:0];
      ds_q <= s_if.HSIZE;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic drv0(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                      input logic w, input logic [2:0] sz);
    m0_if.HSEL = sel; m0_if.HTRANS = tr; m0_if.HADDR = a; m0_if.HWRITE = w; m0_if.HSIZE = sz;
  endtask

  task automatic drv1(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                      input logic w, input logic [2:0] sz);
    m1_if.HSEL = sel; m1_if.HTRANS = tr; m1_if.HADDR = a; m1_if.HWRITE = w; m1_if.HSIZE = sz;
  endtask

  task automatic drvf(input logic s0, input logic [31:0] a0, input logic s1,
                      input logic [31:0] a1);
    f0_if.HSEL = s0; f0_if.HTRANS = s0 ? HTRANS_NONSEQ : HTRANS_IDLE; f0_if.HADDR = a0;
    f1_if.HSEL = s1; f1_if.HTRANS = s1 ? HTRANS_NONSEQ : HTRANS_IDLE; f1_if.HADDR = a1;
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    step();
    step();
    HRESETn = 1'b1;
  endtask

  logic [31:0] burst_addr [0:7];
  int          b0, b1, out0, out1;
  int unsigned wr_base;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    burst_addr[0] = 32'h10; burst_addr[1] = 32'h20; burst_addr[2] = 32'h14;
    burst_addr[3] = 32'h24; burst_addr[4] = 32'h18; burst_addr[5] = 32'h28;
    burst_addr[6] = 32'h1C; burst_addr[7] = 32'h2C;
    drv1(0, HTRANS_IDLE, 0, 0, 0);
    m0_if.HWDATA = 32'hFFFF_FFFF;
    m1_if.HWDATA = 0;
    f0_if.HWRITE = 0; f0_if.HSIZE = 3'd2; f0_if.HWDATA = 0;
    f1_if.HWRITE = 0; f1_if.HSIZE = 3'd2; f1_if.HWDATA = 0;
    drvf(0, 0, 0, 0);

    // Reset: outputs quiet even with M0 requesting.
    HRESETn = 1'b0;
    drv0(1, HTRANS_NONSEQ, 32'h40, 1, 3'd2);
    step(); #1;
    chk("rst_s_hsel", s_if.HSEL, 0);
    chk("rst_s_htrans", s_if.HTRANS, 0);
    chk("rst_s_haddr", s_if.HADDR, 0);
    chk("rst_s_hwdata", s_if.HWDATA, 0);
    chk("rst_m0_hready", m0_if.HREADY, 1);
    chk("rst_m1_hready", m1_if.HREADY, 1);
    chk("rst_m0_hresp", m0_if.HRESP, 0);
    chk("rst_m1_hresp", m1_if.HRESP, 0);
    drv0(0, HTRANS_IDLE, 0, 0, 0);
    step();
    HRESETn = 1'b1;

    // M0 alone: write then read back.
    step(); drv0(1, HTRANS_NONSEQ, 32'h100, 1, 3'd2); #1;
    chk("s1_wr_hready", m0_if.HREADY, 1);
    chk("s1_wr_htrans", s_if.HTRANS, 2'b10);
    chk("s1_wr_haddr", s_if.HADDR, 32'h100);
    chk("s1_wr_hwrite", s_if.HWRITE, 1);
    step(); drv0(1, HTRANS_NONSEQ, 32'h100, 0, 3'd2); m0_if.HWDATA = 32'hDEAD_BEEF; #1;
    chk("s1_rd_hready", m0_if.HREADY, 1);
    chk("s1_hwdata", s_if.HWDATA, 32'hDEAD_BEEF);
    chk("s1_rd_htrans", s_if.HTRANS, 2'b10);
    chk("s1_rd_hwrite", s_if.HWRITE, 0);
    step(); drv0(0, HTRANS_IDLE, 0, 0, 0); m0_if.HWDATA = 32'h1234_5678; #1;
    chk("s1_m0_rdata", m0_if.HRDATA, 32'hDEAD_BEEF);
    chk("s1_m1_rdata", m1_if.HRDATA, 32'hDEAD_BEEF);
    chk("s1_idle_hsel", s_if.HSEL, 0);
    chk("s1_idle_htrans", s_if.HTRANS, 0);
    chk("s1_hold_haddr", s_if.HADDR, 32'h100);
    step(); #1;
    chk("s1_dpidle_hwdata", s_if.HWDATA, 0);

    // Simultaneous reads after reset: M0 first, M1 stalls one cycle.
    do_reset();
    step(); drv0(1, HTRANS_NONSEQ, 32'h0, 0, 3'd2); drv1(1, HTRANS_NONSEQ, 32'h4, 0, 3'd2); #1;
    chk("s2_tie_haddr", s_if.HADDR, 32'h0);
    chk("s2_m1_hready_a", m1_if.HREADY, 1);
    step(); drv0(0, HTRANS_IDLE, 0, 0, 0); drv1(0, HTRANS_IDLE, 0, 0, 0); #1;
    chk("s2_m1_stall", m1_if.HREADY, 0);
    chk("s2_hold_haddr", s_if.HADDR, 32'h4);
    chk("s2_hold_hsel", s_if.HSEL, 1);
    chk("s2_m0_rdata", m0_if.HRDATA, 32'h1000_0000);
    step(); #1;
    chk("s2_m1_hready", m1_if.HREADY, 1);
    chk("s2_m1_rdata", m1_if.HRDATA, 32'h1000_0001);
    chk("s2_idle_hsel", s_if.HSEL, 0);

    // Competing 4-beat read bursts: slave sees alternating NONSEQ beats.
    b0 = 0; b1 = 0; out0 = -1; out1 = -1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      step();
      if (b0 < 4) drv0(1, (b0 == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 32'h10 + 32'(4 * b0), 0, 3'd2);
      else drv0(0, HTRANS_IDLE, 0, 0, 0);
      if (b1 < 4) drv1(1, (b1 == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 32'h20 + 32'(4 * b1), 0, 3'd2);
      else drv1(0, HTRANS_IDLE, 0, 0, 0);
      #1;
      if (out0 >= 0 && m0_if.HREADY) begin
        chk("s3_m0_rdata", m0_if.HRDATA, 32'h1000_0004 + 32'(out0));
        out0 = -1;
      end
      if (out1 >= 0 && m1_if.HREADY) begin
        chk("s3_m1_rdata", m1_if.HRDATA, 32'h1000_0008 + 32'(out1));
        out1 = -1;
      end
      if (cyc < 8) begin
        chk("s3_htrans", s_if.HTRANS, 2'b10);
        chk("s3_haddr", s_if.HADDR, burst_addr[cyc]);
      end
      if (b0 < 4 && m0_if.HREADY) begin out0 = b0; b0++; end
      if (b1 < 4 && m1_if.HREADY) begin out1 = b1; b1++; end
    end
    chk("s3_m0_done", (b0 == 4 && out0 < 0), 1);
    chk("s3_m1_done", (b1 == 4 && out1 < 0), 1);

    // M1 byte write to lane 3 of 0x200 while M0 waits.
    step(); drv0(1, HTRANS_NONSEQ, 32'h300, 0, 3'd2); #1;
    chk("s4_pre_haddr", s_if.HADDR, 32'h300);
    step(); drv0(1, HTRANS_NONSEQ, 32'h304, 0, 3'd2); drv1(1, HTRANS_NONSEQ, 32'h203, 1, 3'd0); #1;
    chk("s4_m1_haddr", s_if.HADDR, 32'h203);
    chk("s4_hsize", s_if.HSIZE, 0);
    chk("s4_hwrite", s_if.HWRITE, 1);
    step(); drv0(0, HTRANS_IDLE, 0, 0, 0); drv1(0, HTRANS_IDLE, 0, 0, 0);
    m0_if.HWDATA = 32'h5555_5555; m1_if.HWDATA = 32'hAA00_0000; #1;
    chk("s4_hwdata_m1", s_if.HWDATA, 32'hAA00_0000);
    chk("s4_m0_stall", m0_if.HREADY, 0);
    chk("s4_hold_haddr", s_if.HADDR, 32'h304);
    step(); #1;
    chk("s4_m0_rdata", m0_if.HRDATA, 32'h1000_00C1);
    step(); drv0(1, HTRANS_NONSEQ, 32'h200, 0, 3'd2); #1;
    step(); drv0(0, HTRANS_IDLE, 0, 0, 0); #1;
    chk("s4_word", m0_if.HRDATA, 32'hAA00_0080);

    // Reset while M1 is pending: nothing reaches the slave afterwards.
    do_reset();
    step(); drv0(1, HTRANS_NONSEQ, 32'hF0, 1, 3'd2); drv1(1, HTRANS_NONSEQ, 32'hF4, 1, 3'd2); #1;
    chk("s5_win_haddr", s_if.HADDR, 32'hF0);
    step(); drv0(0, HTRANS_IDLE, 0, 0, 0); drv1(0, HTRANS_IDLE, 0, 0, 0);
    m0_if.HWDATA = 32'h1111_1111; m1_if.HWDATA = 32'h2222_2222; #1;
    chk("s5_m1_pend", m1_if.HREADY, 0);
    wr_base = wr_cnt;
    HRESETn = 1'b0;
    #1;
    chk("s5_rst_m1_hready", m1_if.HREADY, 1);
    chk("s5_rst_hsel", s_if.HSEL, 0);
    step(); step();
    HRESETn = 1'b1;
    repeat (3) step();
    #1;
    chk("s5_no_write", wr_cnt, wr_base);
    chk("s5_mem_f4", mem[8'h3D], 32'h1000_003D);
    chk("s5_mem_f0", mem[8'h3C], 32'h1000_003C);

    // Slave wait state: live request is parked, then forwarded.
    step(); slv_ready = 1'b0; drv0(1, HTRANS_NONSEQ, 32'h8, 0, 3'd2); #1;
    chk("s6_stall_hsel", s_if.HSEL, 0);
    chk("s6_stall_htrans", s_if.HTRANS, 0);
    chk("s6_stall_s_hready", s_if.HREADY, 0);
    chk("s6_stall_haddr", s_if.HADDR, 0);
    chk("s6_m0_hready", m0_if.HREADY, 1);
    step(); slv_ready = 1'b1; drv0(0, HTRANS_IDLE, 0, 0, 0); #1;
    chk("s6_m0_stall", m0_if.HREADY, 0);
    chk("s6_haddr", s_if.HADDR, 32'h8);
    chk("s6_hsel", s_if.HSEL, 1);
    step(); #1;
    chk("s6_rdata", m0_if.HRDATA, 32'h1000_0002);
    chk("s6_m0_hready_b", m0_if.HREADY, 1);

    // Fixed priority: M1 waits until M0 goes idle.
    do_reset();
    step(); drvf(1, 32'h0, 1, 32'h4); #1;
    chk("fp_t0_haddr", fs_if.HADDR, 32'h0);
    step(); drvf(1, 32'h8, 0, 0); #1;
    chk("fp_t1_haddr", fs_if.HADDR, 32'h8);
    chk("fp_t1_m1_hready", f1_if.HREADY, 0);
    step(); drvf(1, 32'hC, 0, 0); #1;
    chk("fp_t2_haddr", fs_if.HADDR, 32'hC);
    chk("fp_t2_m1_hready", f1_if.HREADY, 0);
    step(); drvf(0, 0, 0, 0); #1;
    chk("fp_t3_haddr", fs_if.HADDR, 32'h4);
    chk("fp_t3_hsel", fs_if.HSEL, 1);
    step(); #1;
    chk("fp_t4_m1_hready", f1_if.HREADY, 1);
    chk("fp_t4_hsel", fs_if.HSEL, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
